// File: rtl/i2c_pkg.sv
// Shared types and constants for the autonomous I2C write-frame generator.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_DONE
  } state_e;

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;

  localparam int BITS_PER_SLOT = 9;
  localparam int NUM_BYTES     = 3;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: one-cycle pulse every CLK_DIV clocks.
module i2c_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: emits START, {DEV_ADDR,W}, REG_ADDR, DATA, STOP after reset.
// Define I2C_REPEAT_EN to resend the frame forever instead of stopping after one.
module i2c_master_tx #(
  parameter int         CLK_DIV    = 4,
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter logic [7:0] REG_ADDR   = 8'h00,
  parameter logic [7:0] DATA       = 8'hA5,
  parameter int         IDLE_TICKS = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic sck,
  output logic sda
);
  import i2c_pkg::*;

  localparam int IW = $clog2(IDLE_TICKS + 2);

  state_e        state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [3:0]    bit_q,   bit_d;
  logic [1:0]    byte_q,  byte_d;
  logic [IW-1:0] idle_q,  idle_d;
  logic          sck_q,   sck_d;
  logic          sda_q,   sda_d;
  logic          tick;
  logic [7:0]    cur_byte;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  always_comb begin
    unique case (byte_d)
      2'd0:    cur_byte = {DEV_ADDR, 1'b0};
      2'd1:    cur_byte = REG_ADDR;
      default: cur_byte = DATA;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    idle_d  = idle_q;
    sck_d   = sck_q;
    sda_d   = sda_q;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (idle_q == IW'(IDLE_TICKS)) begin
            state_d = ST_START;
            phase_d = P0;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + IW'(1);
          end
        end
        ST_START: begin
          if (phase_q == P3) begin
            state_d = ST_BITS;
            phase_d = P0;
            bit_d   = '0;
            byte_d  = '0;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
        ST_BITS: begin
          if (phase_q != P3) begin
            phase_d = phase_q + 2'd1;
          end else begin
            phase_d = P0;
            if (bit_q == 4'(BITS_PER_SLOT - 1)) begin
              bit_d = '0;
              if (byte_q == 2'(NUM_BYTES - 1)) state_d = ST_STOP;
              else                             byte_d  = byte_q + 2'd1;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
        ST_STOP: begin
          // The released P3 phase (1,1) doubles as the first tick of the next
          // idle period, so the frame-to-frame gap is exactly IDLE_TICKS+3 ticks.
          if (phase_q == P2) begin
            phase_d = P0;
            byte_d  = '0;
            idle_d  = '0;
`ifdef I2C_REPEAT_EN
            state_d = ST_IDLE;
`else
            state_d = ST_DONE;
`endif
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase

      unique case (state_d)
        ST_START: begin
          sck_d = 1'b1;
          sda_d = (phase_d == P0) || (phase_d == P1);
        end
        ST_BITS: begin
          sck_d = phase_d[1];
          sda_d = (bit_d == 4'(BITS_PER_SLOT - 1)) ? 1'b1 : cur_byte[~bit_d[2:0]];
        end
        ST_STOP: begin
          sck_d = phase_d[1];
          sda_d = (phase_d == P3);
        end
        default: begin
          sck_d = 1'b1;
          sda_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= P0;
      bit_q   <= '0;
      byte_q  <= '0;
      idle_q  <= '0;
      sck_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      idle_q  <= idle_d;
      sck_q   <= sck_d;
      sda_q   <= sda_d;
    end
  end

  assign sck = sck_q;
  assign sda = sda_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Directed bench for i2c_master_tx with default parameters (CLK_DIV=4, IDLE_TICKS=16).
module tb_i2c_master_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck, sda;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int bad      = 0;
  int t        = 0;

  logic exp_q[$];
  logic got_q[$];

  always #5 clk = ~clk;

  i2c_master_tx dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sck  (sck),
    .sda  (sda)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin
      step();
      check("rst_sck", 32'(sck), 32'd1);
      check("rst_sda", 32'(sda), 32'd1);
    end
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // Watches 600 cycles after release: idle, START, 27 bit slots, STOP.
  task automatic run_frame(input string tag);
    int   start_c, stop_c, fall_c, idle_bad, hs;
    logic ps, pd;
    start_c = -1; stop_c = -1; fall_c = -1; idle_bad = 0; hs = 0;
    ps = 1'b1; pd = 1'b1;
    got_q.delete();
    repeat (600) begin
      step();
      if (cyc < 76 && (sck !== 1'b1 || sda !== 1'b1)) idle_bad++;
      if (ps && sck && (pd !== sda)) begin
        hs++;
        if (!sda && start_c < 0) start_c = cyc;
        if (sda && stop_c < 0)   stop_c  = cyc;
      end
      if (ps && !sck && fall_c < 0) fall_c = cyc;
      if (!ps && sck && got_q.size() < 27) got_q.push_back(sda);
      ps = sck;
      pd = sda;
    end
    check({tag, "_idle_bad"},   32'(idle_bad),     32'd0);
    check({tag, "_start_cyc"},  32'(start_c),      32'd76);
    check({tag, "_sck_fall"},   32'(fall_c),       32'd84);
    check({tag, "_stop_cyc"},   32'(stop_c),       32'd528);
    check({tag, "_hi_edges"},   32'(hs),           32'd2);
    check({tag, "_nbits"},      32'(got_q.size()), 32'd27);
    for (int i = 0; i < 27; i++) begin
      logic b;
      b = (i < got_q.size()) ? got_q[i] : 1'bx;
      check($sformatf("%s_bit%0d", tag, i), 32'(b), 32'(exp_q[i]));
    end
  endtask

  initial begin
    logic [7:0] bytes [3];
    bytes[0] = 8'hA0;
    bytes[1] = 8'h00;
    bytes[2] = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      for (int b = 7; b >= 0; b--) exp_q.push_back(bytes[k][b]);
      exp_q.push_back(1'b1);
    end

    hold_reset(5);
    run_frame("f1");

`ifdef I2C_REPEAT_EN
    t = 0;
    while (t < 200 && sda !== 1'b0) begin
      step();
      t++;
    end
    check("repeat_start_cyc", 32'(cyc), 32'd604);
    check("repeat_start_sck", 32'(sck), 32'd1);
`else
    bad = 0;
    repeat (2000) begin
      step();
      if (sck !== 1'b1 || sda !== 1'b1) bad++;
    end
    check("oneshot_hold", 32'(bad), 32'd0);
`endif

    hold_reset(5);
    repeat (405) step();
    check("mid_pre_sck", 32'(sck), 32'd0);
    check("mid_pre_sda", 32'(sda), 32'd1);
    rst_n = 1'b0;
    step();
    check("mid_rst_sck", 32'(sck), 32'd1);
    check("mid_rst_sda", 32'(sda), 32'd1);
    hold_reset(4);
    run_frame("f2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
